// File: rtl/spike_pkg.sv
// spike_pkg: shared mode encodings and datapath width helper for the spike generator
package spike_pkg;
  localparam logic MODE_RESET_ZERO = 1'b0;
  localparam logic MODE_SUBTRACT   = 1'b1;
  function automatic int diff_w(input int uw);
    return uw + 2;
  endfunction
endpackage

// File: rtl/spike_threshold_cmp.sv
// spike_threshold_cmp: one channel's threshold compare and post-decision membrane value
module spike_threshold_cmp
  import spike_pkg::*;
#(
  parameter int U_W = 8
) (
  input  logic [U_W-1:0] u_i,
  input  logic [U_W-1:0] theta,
  input  logic           blocked_i,
  input  logic           mode,
  output logic           spike_i,
  output logic [U_W-1:0] u_next_i
);
  localparam int DW = diff_w(U_W);
  logic [DW-1:0] diff;
  always_comb begin
    diff     = {{2{u_i[U_W-1]}}, u_i} - {2'b00, theta};
    spike_i  = ~diff[DW-1] & ~blocked_i;
    u_next_i = blocked_i ? '0 :
               spike_i   ? (mode == MODE_SUBTRACT ? diff[U_W-1:0] : '0) :
               u_i;
  end
endmodule

// File: rtl/spike_generator_mc.sv
// spike_generator_mc: registered multi-channel spike generator with per-channel refractory counters
module spike_generator_mc
  import spike_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int U_W   = 8,
  parameter int REF_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [N_CH*U_W-1:0] u,
  input  logic [U_W-1:0]      theta,
  input  logic [REF_W-1:0]    ref_period,
  input  logic                mode,
  output logic                out_valid,
  output logic [N_CH-1:0]     spike,
  output logic [N_CH*U_W-1:0] u_next,
  output logic [N_CH-1:0]     refractory
);
  logic [REF_W-1:0]    cnt_q [N_CH];
  logic [REF_W-1:0]    cnt_d [N_CH];
  logic [N_CH-1:0]     spike_q, spike_d, blocked, spk_c;
  logic [N_CH*U_W-1:0] u_next_q, u_next_d, unx_c;
  logic                out_valid_q, out_valid_d;
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign blocked[g]    = |cnt_q[g];
    assign refractory[g] = |cnt_q[g];
    spike_threshold_cmp #(.U_W(U_W)) u_cmp (
      .u_i      (u[g*U_W +: U_W]),
      .theta    (theta),
      .blocked_i(blocked[g]),
      .mode     (mode),
      .spike_i  (spk_c[g]),
      .u_next_i (unx_c[g*U_W +: U_W])
    );
  end
  always_comb begin
    out_valid_d = in_valid;
    spike_d     = in_valid ? spk_c : '0;
    u_next_d    = in_valid ? unx_c : u_next_q;
    cnt_d       = cnt_q;
    for (int i = 0; i < N_CH; i++)
      if (in_valid)
        cnt_d[i] = spk_c[i] ? ref_period : blocked[i] ? cnt_q[i] - REF_W'(1) : cnt_q[i];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      spike_q     <= '0;
      u_next_q    <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      spike_q     <= spike_d;
      u_next_q    <= u_next_d;
      cnt_q       <= cnt_d;
    end
  end
  assign out_valid = out_valid_q;
  assign spike     = spike_q;
  assign u_next    = u_next_q;
endmodule

// File: tb/tb_spike_generator_mc.sv
// tb_spike_generator_mc: directed vectors with a queue scoreboard checked by an output monitor
module tb_spike_generator_mc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] u = '0;
  logic [7:0]  theta = '0;
  logic [3:0]  ref_period = '0;
  logic        mode = 1'b0;
  logic        out_valid;
  logic [3:0]  spike;
  logic [31:0] u_next;
  logic [3:0]  refractory;

  typedef struct packed {
    logic [3:0]  spk;
    logic [31:0] unx;
    logic [3:0]  rfr;
  } exp_t;
  exp_t  sb [$];
  string nm_q [$];
  int    n_cmp = 0;
  int    n_bad = 0;

  spike_generator_mc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .u(u), .theta(theta),
    .ref_period(ref_period), .mode(mode), .out_valid(out_valid), .spike(spike),
    .u_next(u_next), .refractory(refractory)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic [7:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out_valid: spike=%b u_next=%h with empty scoreboard", spike, u_next);
      end else begin
        exp_t  e;
        string nm;
        e  = sb.pop_front();
        nm = nm_q.pop_front();
        if (spike !== e.spk || u_next !== e.unx || refractory !== e.rfr) begin
          n_bad++;
          $display("FAIL %s: got spike=%b u_next=%h refr=%b, want spike=%b u_next=%h refr=%b",
                   nm, spike, u_next, refractory, e.spk, e.unx, e.rfr);
        end
      end
    end else if (rst_n) begin
      n_cmp++;
      if (spike !== 4'b0) begin
        n_bad++;
        $display("FAIL idle_spike: got spike=%b want 0000", spike);
      end
    end
  end

  task automatic send(input logic [31:0] uv, input logic [7:0] th, input logic [3:0] rp,
                      input logic m, input logic [3:0] es, input logic [31:0] eu,
                      input logic [3:0] er, input string nm);
    @(negedge clk);
    in_valid = 1'b1; u = uv; theta = th; ref_period = rp; mode = m;
    sb.push_back('{spk: es, unx: eu, rfr: er});
    nm_q.push_back(nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; u = 32'hA5A5_A5A5;
    end
  endtask

  task automatic chk_zero(input string nm);
    n_cmp++;
    if (out_valid !== 1'b0 || spike !== 4'b0 || u_next !== 32'b0 || refractory !== 4'b0) begin
      n_bad++;
      $display("FAIL %s: got ov=%b spike=%b u_next=%h refr=%b, want all zero",
               nm, out_valid, spike, u_next, refractory);
    end
  endtask

  task automatic refr_seq(input int gap, input string nm);
    send(pk(8'd100, 8'd9, 8'd0, 8'd0), 8'd10, 4'd2, 1'b1, 4'b0001, pk(8'd90, 8'd9, 8'd0, 8'd0), 4'b0001, {nm, "_s0"});
    idle(gap);
    send(pk(8'd100, 8'd9, 8'd0, 8'd0), 8'd10, 4'd2, 1'b1, 4'b0000, pk(8'd0, 8'd9, 8'd0, 8'd0), 4'b0001, {nm, "_s1"});
    idle(gap);
    send(pk(8'd100, 8'd9, 8'd0, 8'd0), 8'd10, 4'd2, 1'b1, 4'b0000, pk(8'd0, 8'd9, 8'd0, 8'd0), 4'b0000, {nm, "_s2"});
    idle(gap);
    send(pk(8'd100, 8'd9, 8'd0, 8'd0), 8'd10, 4'd2, 1'b1, 4'b0001, pk(8'd90, 8'd9, 8'd0, 8'd0), 4'b0001, {nm, "_s3"});
    idle(gap);
    send(pk(8'd100, 8'd9, 8'd0, 8'd0), 8'd10, 4'd2, 1'b1, 4'b0000, pk(8'd0, 8'd9, 8'd0, 8'd0), 4'b0001, {nm, "_s4"});
    send(pk(8'd0, 8'd0, 8'd0, 8'd0), 8'd10, 4'd2, 1'b1, 4'b0000, pk(8'd0, 8'd0, 8'd0, 8'd0), 4'b0000, {nm, "_drain"});
  endtask

  initial begin
    in_valid = 1'b1; u = 32'h7F7F_7F7F; theta = 8'd0; ref_period = 4'd3;
    repeat (3) @(negedge clk);
    chk_zero("reset_hold");
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk_zero("reset_release");

    send(pk(8'd19, 8'd20, 8'd21, 8'h80), 8'd20, 4'd0, 1'b0, 4'b0110, pk(8'd19, 8'd0, 8'd0, 8'h80), 4'b0000, "thr_boundary");
    send(pk(8'd127, 8'd50, 8'd49, 8'hFF), 8'd50, 4'd0, 1'b1, 4'b0011, pk(8'd77, 8'd0, 8'd49, 8'hFF), 4'b0000, "subtract_127");
    send(pk(8'd50, 8'd127, 8'h80, 8'd51), 8'd50, 4'd0, 1'b1, 4'b1011, pk(8'd0, 8'd77, 8'h80, 8'd1), 4'b0000, "subtract_50");
    send(pk(8'd0, 8'hFF, 8'd5, 8'd127), 8'd0, 4'd0, 1'b1, 4'b1101, pk(8'd0, 8'hFF, 8'd5, 8'd127), 4'b0000, "theta_zero");
    send(pk(8'd127, 8'd127, 8'd127, 8'd127), 8'd255, 4'd0, 1'b0, 4'b0000, pk(8'd127, 8'd127, 8'd127, 8'd127), 4'b0000, "theta_max");
    idle(2);

    refr_seq(0, "refr");
    idle(2);
    refr_seq(3, "gapped");
    idle(2);

    send(pk(8'd100, 8'd0, 8'd0, 8'd0), 8'd10, 4'd15, 1'b0, 4'b0001, pk(8'd0, 8'd0, 8'd0, 8'd0), 4'b0001, "pre_reset_spike");
    @(negedge clk);
    in_valid = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    chk_zero("mid_refr_reset");
    send(pk(8'd100, 8'd0, 8'd0, 8'd0), 8'd10, 4'd15, 1'b1, 4'b0001, pk(8'd90, 8'd0, 8'd0, 8'd0), 4'b0001, "post_reset_fire");
    idle(3);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spike_generator_mc.md
# spike_generator_mc

Multi-channel, clocked successor to the single-channel combinational spike comparator. Each valid sample, it compares N_CH signed membrane potentials against a shared threshold and emits one registered spike per channel. It also enforces a per-channel refractory period and returns the post-spike membrane value, so the upstream neuron update stage can write it back. It sits between the membrane accumulator and the spike router.

## Interface
Parameters:
- N_CH, 4, number of channels.
- U_W, 8, membrane width; two's complement.
- REF_W, 4, refractory counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  sample strobe; u, theta, ref_period and mode are sampled only when high.
- u  in  N_CH*U_W  packed signed potentials; channel i is at bits [i*U_W +: U_W].
- theta  in  U_W  unsigned threshold.
- ref_period  in  REF_W  refractory length in valid samples; 0 disables refractoriness.
- mode  in  1  0 = reset-to-zero, 1 = subtract-threshold.
- out_valid  out  1  registered copy of in_valid.
- spike  out  N_CH  registered spike flags.
- u_next  out  N_CH*U_W  registered post-decision potentials, same packing as u.
- refractory  out  N_CH  high while the channel's counter is non-zero.

## Operation
- Per channel: diff = sext(u_i) − zext(theta), computed at U_W+2 bits. fire_i = (diff ≥ 0), i.e. the sign bit of diff is 0.
- Let cnt_i be the refractory counter. blocked_i = (cnt_i != 0), evaluated before this sample's update.
- spike_i = fire_i & ~blocked_i.
- u_next_i:
  - blocked_i: 0.
  - spike_i and mode = 0: 0.
  - spike_i and mode = 1: diff[U_W-1:0]. Always in range, because 0 ≤ diff ≤ 2^(U_W−1)−1.
  - otherwise: u_i unchanged.
- Counter update, only on in_valid:
  - If spike_i: cnt_i ← ref_period.
  - Else if blocked_i: cnt_i ← cnt_i − 1.
  - Else: hold.
- With in_valid low, counters hold, out_valid = 0, and spike = 0. u_next holds its last value.
- theta = 0: every non-refractory channel with u_i ≥ 0 fires.
- Negative u_i never fires.
- Counter wrap-around is impossible: cnt_i only decrements while non-zero.
- ref_period changing mid-refractory affects only subsequent spikes. The running count is not reloaded.

## Timing
- Latency is 1 cycle: sample on edge k appears on spike/u_next/out_valid after edge k, valid during cycle k+1.
- Full throughput: one sample per cycle. There is no backpressure; the consumer must accept every out_valid.
- Refractory window: spike on sample s blocks samples s+1 … s+ref_period. The channel is eligible again at s+ref_period+1.
- The refractory output reflects counters after the update, aligned with spike. It is high in the same cycle as a spike when ref_period ≠ 0.
- Reset, when rst_n is low at an edge:
  - out_valid, spike, u_next, refractory, and all cnt_i go to 0.
  - Any in-flight sample is dropped.
  - Reset mid-refractory clears the counters, so the first post-reset sample may fire.
- Reset dominates in_valid in the same cycle.

## Structure
- Package spike_pkg holds:
  - MODE_RESET_ZERO = 1'b0 and MODE_SUBTRACT = 1'b1.
  - A function for the signed-extend-and-subtract width, U_W+2.
- Sub-module spike_threshold_cmp, instantiated N_CH times in a generate loop:
  - Inputs: u_i, theta, blocked_i, mode.
  - Outputs: spike_i and u_next_i.
  - Purely combinational.
- Counters and output registers live in the top level.

## Test plan
Defaults: U_W=8, N_CH=4, REF_W=4.
- Reset: hold rst_n=0 with in_valid=1 and u=all 0x7F. Then all outputs are 0 and remain 0 for the cycle after release with in_valid=0.
- Threshold boundary: theta=20, mode=0, ref_period=0, u = {19, 20, 21, −128}. Then spike = 4'b0110 and u_next = {19, 0, 0, −128} one cycle later.
- Subtract mode: theta=50, mode=1, u_0 = 127 → spike_0=1 and u_next_0=77. u_0 = 50 → spike_0=1 and u_next_0=0.
- Refractory: ref_period=2 and theta=10, with u_0 = 100 on 5 consecutive valid samples.
  - spike_0 = 1, 0, 0, 1, 0.
  - refractory_0 = 1, 1, 0, 1, 1.
  - u_next_0 = 0 on blocked samples.
- Gapped valid: same refractory setup, but with in_valid low for 3 cycles between samples. The counter does not decrement during gaps, so the spike pattern is identical.
- Reset mid-refractory: after a spike with ref_period=15, pulse rst_n low for 1 cycle. The next valid sample with u ≥ theta fires immediately.
